// File: rtl/dr_pkg.sv
// Shared dual-rail definitions: rail-pair codes, controller states and pair classifiers.
package dr_pkg;

  localparam logic [1:0] RAIL_NULL    = 2'b00;
  localparam logic [1:0] RAIL_DATA0   = 2'b01;
  localparam logic [1:0] RAIL_DATA1   = 2'b10;
  localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Pairs are packed as {true_rail, false_rail}.
  function automatic logic is_null(input logic [1:0] pair);
    return pair == RAIL_NULL;
  endfunction

  function automatic logic is_data(input logic [1:0] pair);
    return (pair == RAIL_DATA0) || (pair == RAIL_DATA1);
  endfunction

  function automatic logic is_illegal(input logic [1:0] pair);
    return pair == RAIL_ILLEGAL;
  endfunction

endpackage

// File: rtl/dr_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module dr_rr_arbiter #(
  parameter  int CH = 4,
  localparam int PW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic [CH-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [CH-1:0] gnt,
  output logic          valid
);

  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    valid = 1'b0;
    for (int i = 0; i < CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CH) idx = idx - CH;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rw_ctrl_nch.sv
// Multi-channel dual-rail RW controller: round-robin grant, four-phase hold/release,
// sticky illegal-code and hold-timeout error flags.
module mem_rw_ctrl_nch
  import dr_pkg::*;
#(
  parameter int CH  = 4,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] ph0_t,
  input  logic [CH-1:0] ph0_f,
  input  logic [CH-1:0] mi_t,
  input  logic [CH-1:0] mi_f,
  input  logic          err_clr,
  output logic          rw_t,
  output logic          rw_f,
  output logic [CH-1:0] ack,
  output logic [CH-1:0] err
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;
  localparam int HW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] g;
  logic [HW-1:0] hold_cnt;

  logic [CH-1:0] complete, chan_null, illegal, eligible;
  logic [CH-1:0] arb_gnt, err_set, tmo_err;
  logic          arb_valid, arb_wr;
  logic [PW-1:0] arb_idx, g_next;
  logic          g_null, g_ill, tmo_hit;

  always_comb begin
    complete  = '0;
    chan_null = '0;
    illegal   = '0;
    for (int i = 0; i < CH; i++) begin
      complete[i]  = is_data({ph0_t[i], ph0_f[i]}) && is_data({mi_t[i], mi_f[i]});
      chan_null[i] = is_null({ph0_t[i], ph0_f[i]}) && is_null({mi_t[i], mi_f[i]});
      illegal[i]   = is_illegal({ph0_t[i], ph0_f[i]}) || is_illegal({mi_t[i], mi_f[i]});
    end
  end

  assign eligible = complete & ~illegal & ~err;

  dr_rr_arbiter #(.CH(CH)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < CH; i++) begin
      if (arb_gnt[i]) arb_idx = PW'(i);
    end
  end

  // Granted lanes are complete DATA, so a high true rail on both pairs means DATA1 (write).
  assign arb_wr  = |(arb_gnt & ph0_t & mi_t);
  assign g_null  = chan_null[g];
  assign g_ill   = illegal[g];
  assign tmo_hit = (TMO != 0) && (hold_cnt == HW'(TMO));
  assign g_next  = (int'(g) >= CH - 1) ? '0 : g + 1'b1;

  // ack holds the one-hot grant while in HOLD, so it doubles as the timeout error mask.
  assign tmo_err = ack & {CH{(state == ST_HOLD) && tmo_hit && !g_null}};
  assign err_set = illegal | tmo_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      g        <= '0;
      hold_cnt <= '0;
      rw_t     <= 1'b0;
      rw_f     <= 1'b0;
      ack      <= '0;
      err      <= '0;
    end else begin
      err <= (err & ~{CH{err_clr}}) | err_set;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state    <= ST_HOLD;
            g        <= arb_idx;
            hold_cnt <= '0;
            rw_t     <= arb_wr;
            rw_f     <= !arb_wr;
            ack      <= arb_gnt;
          end
        end
        ST_HOLD: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
          if (g_ill || g_null || tmo_hit) begin
            state <= ST_RELEASE;
            rw_t  <= 1'b0;
            rw_f  <= 1'b0;
            ack   <= '0;
          end
        end
        ST_RELEASE: begin
          state  <= ST_IDLE;
          rr_ptr <= g_next;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rw_ctrl_nch.sv
// Directed bench for mem_rw_ctrl_nch (CH=4, TMO=8); grants are checked by a scoreboard monitor.
module tb_mem_rw_ctrl_nch;
  localparam int CH  = 4;
  localparam int TMO = 8;
  localparam logic [1:0] NUL = 2'b00;
  localparam logic [1:0] D0  = 2'b01;
  localparam logic [1:0] D1  = 2'b10;
  localparam logic [1:0] ILL = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] ph0_t, ph0_f, mi_t, mi_f;
  logic          err_clr;
  logic          rw_t, rw_f;
  logic [CH-1:0] ack, err;

  always #5 clk = ~clk;

  mem_rw_ctrl_nch #(.CH(CH), .TMO(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .ph0_t   (ph0_t),
    .ph0_f   (ph0_f),
    .mi_t    (mi_t),
    .mi_f    (mi_f),
    .err_clr (err_clr),
    .rw_t    (rw_t),
    .rw_f    (rw_f),
    .ack     (ack),
    .err     (err)
  );

  typedef struct packed {
    logic [CH-1:0] ack;
    logic          rw_t;
    logic          rw_f;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CH-1:0] prev_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic set_ch(input int i, input logic [1:0] ph, input logic [1:0] mi);
    ph0_t[i] = ph[1];
    ph0_f[i] = ph[0];
    mi_t[i]  = mi[1];
    mi_f[i]  = mi[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int ch, input logic wr);
    exp_t e;
    e.ack  = CH'(1) << ch;
    e.rw_t = wr;
    e.rw_f = !wr;
    sb_q.push_back(e);
  endtask

  // Monitor: every new grant (ack rising from zero) must match the oldest expectation.
  initial begin
    prev_ack = '0;
    forever begin
      @(negedge clk);
      if (ack != '0 && prev_ack == '0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: ack=%b rw=%b%b required no grant", ack, rw_t, rw_f);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("grant", {ack, rw_t, rw_f}, e);
        end
      end
      prev_ack = ack;
    end
  end

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    ph0_t = '0; ph0_f = '0; mi_t = '0; mi_f = '0;
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_after_reset", {rw_t, rw_f, ack, err}, 0);
    end

    // single channel write, hold stability, release, then read
    set_ch(1, D1, D1); expect_grant(1, 1'b1);
    tick(); check("a_write", {ack, rw_t, rw_f}, {4'b0010, 2'b10});
    set_ch(1, D0, D1);
    tick(); check("a_hold_stable", {rw_t, rw_f, ack}, {2'b10, 4'b0010});
    set_ch(1, NUL, NUL);
    tick(); check("a_release", {rw_t, rw_f, ack}, 0);
    tick(); tick();
    set_ch(1, D0, D1); expect_grant(1, 1'b0);
    tick(); check("a_read", {ack, rw_t, rw_f}, {4'b0010, 2'b01});
    set_ch(1, NUL, NUL);
    tick(); check("a_release2", {rw_t, rw_f, ack}, 0);
    tick(); tick();

    rst = 1'b1; tick(); rst = 1'b0;
    check("reset_idle", {rw_t, rw_f, ack, err}, 0);

    // simultaneous ch0/ch2, two-cycle NULL gap, wrap to ch0 from rr_ptr=3
    set_ch(0, D0, D0); set_ch(2, D1, D1); expect_grant(0, 1'b0);
    tick(); check("c_first_ch0", ack, 4'b0001);
    expect_grant(2, 1'b1); set_ch(0, NUL, NUL);
    tick(); check("c_rel_ch0", {rw_t, rw_f, ack}, 0);
    tick(); check("c_null_gap", {rw_t, rw_f, ack}, 0);
    tick(); check("c_grant_ch2", {ack, rw_t, rw_f}, {4'b0100, 2'b10});
    set_ch(2, NUL, NUL);
    tick(); check("c_rel_ch2", {rw_t, rw_f, ack}, 0);
    set_ch(0, D1, D1); set_ch(2, D1, D1); expect_grant(0, 1'b1);
    tick(); check("c_gap2", ack, 0);
    tick(); check("c_wrap_ch0", ack, 4'b0001);
    set_ch(0, NUL, NUL); set_ch(2, NUL, NUL);
    tick(); tick(); tick();

    // illegal code on ch3; err_clr loses to a simultaneous set; err blocks arbitration
    set_ch(3, D1, ILL);
    tick(); check("d_err_set", err, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick(); check("d_no_grant_illegal", ack, 0);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("d_set_wins", err, 4'b1000);
    set_ch(3, D1, D1);
    for (int i = 0; i < 3; i++) begin
      tick(); check("d_skip_err", {ack, err}, {4'b0000, 4'b1000});
    end
    set_ch(3, NUL, NUL);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("d_err_cleared", err, 0);
    tick();

    // hold timeout on ch0 (TMO=8), then ch1 served
    set_ch(0, D1, D0); expect_grant(0, 1'b0);
    tick(); check("e_grant_ch0", ack, 4'b0001);
    set_ch(1, D1, D1); expect_grant(1, 1'b1);
    repeat (7) tick();
    tick(); check("e_still_hold", {ack, err}, {4'b0001, 4'b0000});
    tick(); check("e_timeout", {rw_t, rw_f, ack, err}, {2'b00, 4'b0000, 4'b0001});
    tick(); check("e_release_gap", ack, 0);
    tick(); check("e_grant_ch1", {ack, rw_t, rw_f}, {4'b0010, 2'b10});
    set_ch(0, NUL, NUL); set_ch(1, NUL, NUL);
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tick(); check("e_err_cleared", err, 0);

    // partial channel is ignored; reset mid-HOLD
    set_ch(2, D1, NUL);
    for (int i = 0; i < 5; i++) begin
      repeat (10) tick();
      check("f_partial", {ack, err}, 0);
    end
    set_ch(1, D1, D1); expect_grant(1, 1'b1);
    tick(); check("f_grant_ch1", ack, 4'b0010);
    rst = 1'b1; tick(); rst = 1'b0;
    check("f_reset_in_hold", {rw_t, rw_f, ack, err}, 0);
    set_ch(3, D1, D1); expect_grant(1, 1'b1);
    tick(); check("f_ptr_reset", ack, 4'b0010);
    set_ch(1, NUL, NUL); set_ch(2, NUL, NUL); set_ch(3, NUL, NUL);
    tick(); tick(); tick();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
